// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes used by the main decoder and the
// boot loader's state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_ITYPE);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses
// combinationally with the fourth byte so the caller can register the write.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            shreg <= 24'h0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (byte_valid) begin
            idx   <= idx + 2'd1;
            shreg <= {byte_data, shreg[23:8]};
        end
    end

    // After three bytes shreg holds {b2, b1, b0}; the live byte completes the word.
    assign word_valid = byte_valid && !clear && (idx == 2'd3);
    assign word       = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream to sequential
// word writes, core held in reset until done. Opcode check: IMEM_LOADER_OPCHECK_EN.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        illegal_cnt
);

    localparam int          CW  = ADDR_W + 1;
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [CW-1:0] nwords;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_next;
    logic          last_pend;
    logic [16:0]   len_full;
    logic          len_bad;
    logic          byte_acc;
    logic          word_valid;
    logic [31:0]   word;
    logic          arm;

    assign byte_acc  = rx_valid && rx_ready;
    assign len_full  = {1'b0, rx_data, len_lo};
    assign len_bad   = (len_full == 17'd0) || (len_full > CAP);
    assign wcnt_next = wcnt + CW'(1);
    assign arm       = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state != ST_DATA),
        .byte_valid (byte_acc && state == ST_DATA),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= 8'h0;
            nwords     <= '0;
            wcnt       <= '0;
            last_pend  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Address advances the cycle after a write, but never past the final word.
            if (imem_we) begin
                wcnt <= wcnt_next;
                if (!last_pend) imem_addr <= imem_addr + ADDR_W'(1);
            end
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state     <= ST_LEN0;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        wcnt      <= '0;
                        imem_addr <= '0;
                        last_pend <= 1'b0;
                    end
                end
                ST_LEN0: begin
                    if (byte_acc) begin
                        len_lo <= rx_data;
                        state  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (byte_acc) begin
                        if (len_bad) begin
                            state    <= ST_ERROR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state  <= ST_DATA;
                            nwords <= len_full[CW-1:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= word;
                        if (wcnt_next == nwords) begin
                            last_pend <= 1'b1;
                            rx_ready  <= 1'b0;
                        end
                    end else if (last_pend && !imem_we) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                        last_pend <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= 8'h00;
        end else if (arm) begin
            illegal_cnt <= 8'h00;
        end else if (word_valid && !op_supported(word[6:0]) && illegal_cnt != 8'hFF) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end
`else
    assign illegal_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2): per-cycle vector table plus
// hand-written sequences for opcode checking and reset during a load.
module tb_imem_loader;

    localparam int AW = 2;

`ifdef IMEM_LOADER_OPCHECK_EN
    localparam logic [7:0] EXP_ILL = 8'd1;
`else
    localparam logic [7:0] EXP_ILL = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    illegal_cnt;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst_n   (cpu_rst_n),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          vl;
        logic [7:0]    d;
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          crst;
        logic          bsy;
        logic          dn;
        logic          err;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    vec_t tbl[$];
    wr_t  wr_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic void add(input logic st, input logic vl, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [AW-1:0] addr,
                                input logic [31:0] wd, input logic crst, input logic bsy,
                                input logic dn, input logic err);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.rdy = rdy; v.we = we; v.addr = addr;
        v.wd = wd; v.crst = crst; v.bsy = bsy; v.dn = dn; v.err = err;
        tbl.push_back(v);
    endfunction

    function automatic logic [63:0] obs();
        return 64'({rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done, error, illegal_cnt});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        wr_t w;
        start = s; rx_valid = v; rx_data = d;
        @(posedge clk);
        #1;
        start = 1'b0; rx_valid = 1'b0;
        if (imem_we) begin
            w.a = imem_addr; w.d = imem_wdata;
            wr_q.push_back(w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w1, w2, wa, wb, wc, wd;
        logic [7:0]  opc_bytes [8];
        w1 = 32'h00500093; w2 = 32'h00208133;
        wa = 32'h11100013; wb = 32'h22200033; wc = 32'h33300003; wd = 32'h44400023;

        // st vl data   rdy we addr wdata crst busy done err
        add(1, 0, 8'h00, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h02, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h93, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h50, 1, 0, 0, 32'h0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 1, 0, w1,    0, 1, 0, 0);
        add(0, 1, 8'h33, 1, 0, 1, w1,    0, 1, 0, 0);
        add(1, 0, 8'hFF, 1, 0, 1, w1,    0, 1, 0, 0);
        add(0, 1, 8'h81, 1, 0, 1, w1,    0, 1, 0, 0);
        add(0, 0, 8'hAA, 1, 0, 1, w1,    0, 1, 0, 0);
        add(0, 1, 8'h20, 1, 0, 1, w1,    0, 1, 0, 0);
        add(0, 0, 8'hAA, 1, 0, 1, w1,    0, 1, 0, 0);
        add(0, 1, 8'h00, 0, 1, 1, w2,    0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, w2,    0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, w2,    1, 0, 1, 0);
        add(0, 1, 8'h55, 0, 0, 1, w2,    1, 0, 1, 0);
        // zero length -> ERROR, bytes ignored there, restart
        add(1, 0, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, w2,    0, 0, 0, 1);
        add(0, 1, 8'h12, 0, 0, 0, w2,    0, 0, 0, 1);
        add(1, 0, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h05, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, w2,    0, 0, 0, 1);
        // exact fill of the 4-word memory
        add(1, 0, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h04, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h13, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h10, 1, 0, 0, w2,    0, 1, 0, 0);
        add(0, 1, 8'h11, 1, 1, 0, wa,    0, 1, 0, 0);
        add(0, 1, 8'h33, 1, 0, 1, wa,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 1, wa,    0, 1, 0, 0);
        add(0, 1, 8'h20, 1, 0, 1, wa,    0, 1, 0, 0);
        add(0, 1, 8'h22, 1, 1, 1, wb,    0, 1, 0, 0);
        add(0, 1, 8'h03, 1, 0, 2, wb,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 2, wb,    0, 1, 0, 0);
        add(0, 1, 8'h30, 1, 0, 2, wb,    0, 1, 0, 0);
        add(0, 1, 8'h33, 1, 1, 2, wc,    0, 1, 0, 0);
        add(0, 1, 8'h23, 1, 0, 3, wc,    0, 1, 0, 0);
        add(0, 1, 8'h00, 1, 0, 3, wc,    0, 1, 0, 0);
        add(0, 1, 8'h40, 1, 0, 3, wc,    0, 1, 0, 0);
        add(0, 1, 8'h44, 0, 1, 3, wd,    0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 3, wd,    0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 3, wd,    1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs(), 64'h0);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].st, tbl[k].vl, tbl[k].d);
            check($sformatf("vec%0d", k), obs(),
                  64'({tbl[k].rdy, tbl[k].we, tbl[k].addr, tbl[k].wd,
                       tbl[k].crst, tbl[k].bsy, tbl[k].dn, tbl[k].err, 8'h00}));
        end

        // Opcode check: 0x0000006F (jal, unsupported) then 0x00000013
        opc_bytes = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        wr_q.delete();
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h02);
        cyc(0, 1, 8'h00);
        for (int i = 0; i < 8; i++) cyc(0, 1, opc_bytes[i]);
        for (int i = 0; i < 8 && !done; i++) cyc(0, 0, 8'h00);
        check("opc_done", 64'(done), 64'd1);
        check("opc_illegal_cnt", 64'(illegal_cnt), 64'(EXP_ILL));
        check("opc_write_count", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() >= 2) begin
            check("opc_write0", 64'({wr_q[0].a, wr_q[0].d}), 64'({2'd0, 32'h0000006F}));
            check("opc_write1", 64'({wr_q[1].a, wr_q[1].d}), 64'({2'd1, 32'h00000013}));
        end

        // Reset after 2 of 4 data bytes, then a clean reload
        wr_q.delete();
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h13);
        cyc(0, 1, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_load", obs(), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 1, 8'h50);
        cyc(0, 1, 8'h00);
        check("rst_no_write", 64'({wr_q.size(), busy, cpu_rst_n}), 64'({32'd0, 1'b0, 1'b0}));
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h01);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h13);
        cyc(0, 1, 8'h00);
        cyc(0, 1, 8'h50);
        cyc(0, 1, 8'h00);
        cyc(0, 0, 8'h00);
        check("reload_not_yet_done", 64'({done, cpu_rst_n}), 64'({1'b0, 1'b0}));
        cyc(0, 0, 8'h00);
        check("reload_done", 64'({done, cpu_rst_n, busy}), 64'({1'b1, 1'b1, 1'b0}));
        check("reload_write_count", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() >= 1)
            check("reload_write0", 64'({wr_q[0].a, wr_q[0].d}), 64'({2'd0, 32'h00500013}));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
